// File: rtl/mem_wrap_pkg.sv
// Shared types and elaboration helpers for the tiled 1R1W SRAM wrapper.
// Holds the retention FSM state type and the slice-count and pad-width arithmetic.
package mem_wrap_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    RETN  = 2'd2,
    WAKE  = 2'd3
  } ret_state_e;

  localparam int DEF_DATA_WIDTH  = 1026;
  localparam int DEF_SLICE_WIDTH = 256;

  function automatic int num_slices(input int dw, input int sw);
    return (dw + sw - 1) / sw;
  endfunction

  // Zero bits appended above the logical word to fill the last slice.
  localparam int DEF_PAD_WIDTH =
    num_slices(DEF_DATA_WIDTH, DEF_SLICE_WIDTH) * DEF_SLICE_WIDTH - DEF_DATA_WIDTH;

  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/mem_1r1w_slice.sv
// One SLICE_WIDTH x DEPTH two-port macro: synchronous write, registered read.
// Retention blocks both ports; margin pins are accepted for pin compatibility.
module mem_1r1w_slice
  #(
    parameter int SLICE_WIDTH = 256,
    parameter int DEPTH       = 256,
    parameter int AW          = 8
  )
  (
    input  logic                   CK,
    input  logic                   REN,
    input  logic                   WEN,
    input  logic [AW-1:0]          RA,
    input  logic [AW-1:0]          WA,
    input  logic [SLICE_WIDTH-1:0] DI,
    output logic [SLICE_WIDTH-1:0] DOUT,
    input  logic                   RET,
    input  logic [1:0]             MCSRD,
    input  logic [1:0]             MCSWR,
    input  logic [2:0]             ADME
  );

  logic [SLICE_WIDTH-1:0] mem_array [DEPTH];
  logic [SLICE_WIDTH-1:0] rd_data_reg;
  logic                   unused_margin;

  // Read sees the pre-write contents on an address collision.
  always_ff @(posedge CK) begin
    if (WEN && !RET) begin
      mem_array[WA] <= DI;
    end
    if (REN && !RET) begin
      rd_data_reg <= mem_array[RA];
    end
  end

  assign DOUT          = rd_data_reg;
  assign unused_margin = ^{MCSRD, MCSWR, ADME};

endmodule

// File: rtl/mem_1r1w_bypass_wrapper.sv
// Width-tiled 1R1W SRAM wrapper with write-to-read bypass, a 1- or 2-stage
// read pipeline, and a retention entry/exit handshake with drain and wake timing.
module mem_1r1w_bypass_wrapper
  import mem_wrap_pkg::*;
  #(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = 256,
    parameter int SLICE_WIDTH = DEF_SLICE_WIDTH,
    parameter int RD_LAT      = 1,
    parameter int WAKE_CYCLES = 4,
    parameter int AW          = $clog2(DEPTH)
  )
  (
    input  logic                  CK,
    input  logic                  RSTN,
    input  logic                  REN,
    input  logic                  WEN,
    input  logic [AW-1:0]         RA,
    input  logic [AW-1:0]         WA,
    input  logic [DATA_WIDTH-1:0] DI,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  RVALID,
    output logic                  RDY,
    input  logic                  RET_REQ,
    output logic                  RET_ACK,
    output logic                  ACC_ERR,
    input  logic [1:0]            MCSRD,
    input  logic [1:0]            MCSWR,
    input  logic [2:0]            ADME
  );

  localparam int NUM_SLICES = num_slices(DATA_WIDTH, SLICE_WIDTH);
  localparam int PAD_W      = NUM_SLICES * SLICE_WIDTH;
  localparam int CNT_W      = $clog2(WAKE_CYCLES + 1);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("mem_1r1w_bypass_wrapper: RD_LAT must be 1 or 2");
  end

  ret_state_e            state_reg, state_next;
  logic [CNT_W-1:0]      wake_cnt_reg, wake_cnt_next;
  logic                  rdy, ret_on;
  logic                  ra_ok, wa_ok, rd_acc, wr_acc, byp_hit;
  logic [PAD_W-1:0]      wr_padded, rd_cat;
  logic                  v1_reg, byp1_reg, acc_err_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg, stage1_data, dout_reg;
  logic [1:0]            inflight_cnt;

  assign rdy    = (state_reg == RUN);
  assign ret_on = (state_reg == RETN);

  assign ra_ok   = (32'(RA) < DEPTH);
  assign wa_ok   = (32'(WA) < DEPTH);
  assign rd_acc  = REN & rdy & ra_ok;
  assign wr_acc  = WEN & rdy & wa_ok;
  assign byp_hit = rd_acc & wr_acc & (RA == WA);

  assign wr_padded = PAD_W'(DI);

  genvar gi;
  for (gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
    mem_1r1w_slice #(
      .SLICE_WIDTH (SLICE_WIDTH),
      .DEPTH       (DEPTH),
      .AW          (AW)
    ) u_slice (
      .CK    (CK),
      .REN   (rd_acc),
      .WEN   (wr_acc),
      .RA    (RA),
      .WA    (WA),
      .DI    (wr_padded[gi*SLICE_WIDTH +: SLICE_WIDTH]),
      .DOUT  (rd_cat[gi*SLICE_WIDTH +: SLICE_WIDTH]),
      .RET   (ret_on),
      .MCSRD (MCSRD),
      .MCSWR (MCSWR),
      .ADME  (ADME)
    );
  end

  if (PAD_W > DATA_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rd_cat[PAD_W-1:DATA_WIDTH];
  end

  // Macro returns stale data on a collision; the captured DI replaces it.
  assign stage1_data = byp1_reg ? byp_data_reg : rd_cat[DATA_WIDTH-1:0];

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      v1_reg       <= 1'b0;
      byp1_reg     <= 1'b0;
      byp_data_reg <= '0;
      dout_reg     <= '0;
      acc_err_reg  <= 1'b0;
    end else begin
      v1_reg      <= rd_acc;
      byp1_reg    <= byp_hit;
      acc_err_reg <= (REN & ~rd_acc) | (WEN & ~wr_acc);
      if (byp_hit) begin
        byp_data_reg <= DI;
      end
      if (v1_reg) begin
        dout_reg <= stage1_data;
      end
    end
  end

  // dout_reg is the output stage at latency 2 and the hold register at latency 1.
  if (RD_LAT == 2) begin : g_lat2
    logic v2_reg;
    always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
        v2_reg <= 1'b0;
      end else begin
        v2_reg <= v1_reg;
      end
    end
    assign RVALID       = v2_reg;
    assign DOUT         = dout_reg;
    assign inflight_cnt = {1'b0, v1_reg} + {1'b0, v2_reg};
  end else begin : g_lat1
    assign RVALID       = v1_reg;
    assign DOUT         = v1_reg ? stage1_data : dout_reg;
    assign inflight_cnt = {1'b0, v1_reg};
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg    <= RUN;
      wake_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wake_cnt_reg <= wake_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wake_cnt_next = wake_cnt_reg;
    case (state_reg)
      RUN: begin
        if (RET_REQ) state_next = DRAIN;
      end
      DRAIN: begin
        if (inflight_cnt == 2'd0) state_next = RETN;
      end
      RETN: begin
        if (!RET_REQ) begin
          state_next    = WAKE;
          wake_cnt_next = CNT_W'(WAKE_CYCLES);
        end
      end
      WAKE: begin
        wake_cnt_next = wake_cnt_reg - CNT_W'(1);
        if (wake_cnt_reg == CNT_W'(1)) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign RDY     = rdy;
  assign RET_ACK = ret_on;
  assign ACC_ERR = acc_err_reg;

endmodule

// File: tb/tb_mem_1r1w_bypass_wrapper.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 wrapper share every input,
// each scenario checks the relevant instance against hand-computed values.
module tb_mem_1r1w_bypass_wrapper;
  localparam int DW = 1026;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn, ren, wen, ret_req;
  logic [AW-1:0] ra, wa;
  logic [DW-1:0] di;
  logic [1:0]    mcsrd, mcswr;
  logic [2:0]    adme;

  logic [DW-1:0] dout1, dout2;
  logic          rvalid1, rvalid2, rdy1, rdy2, ret_ack1, ret_ack2, acc_err1, acc_err2;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ones, pat_a5, pat_5a, pat_3c, exp_d;
  logic [mem_wrap_pkg::DEF_PAD_WIDTH-1:0] pad_bits;

  always #5 clk = ~clk;

  mem_1r1w_bypass_wrapper #(
    .DATA_WIDTH(DW), .DEPTH(256), .SLICE_WIDTH(256), .RD_LAT(1), .WAKE_CYCLES(4)
  ) dut1 (
    .CK(clk), .RSTN(rstn), .REN(ren), .WEN(wen), .RA(ra), .WA(wa), .DI(di),
    .DOUT(dout1), .RVALID(rvalid1), .RDY(rdy1), .RET_REQ(ret_req), .RET_ACK(ret_ack1),
    .ACC_ERR(acc_err1), .MCSRD(mcsrd), .MCSWR(mcswr), .ADME(adme)
  );

  mem_1r1w_bypass_wrapper #(
    .DATA_WIDTH(DW), .DEPTH(256), .SLICE_WIDTH(256), .RD_LAT(2), .WAKE_CYCLES(4)
  ) dut2 (
    .CK(clk), .RSTN(rstn), .REN(ren), .WEN(wen), .RA(ra), .WA(wa), .DI(di),
    .DOUT(dout2), .RVALID(rvalid2), .RDY(rdy2), .RET_REQ(ret_req), .RET_ACK(ret_ack2),
    .ACC_ERR(acc_err2), .MCSRD(mcsrd), .MCSWR(mcswr), .ADME(adme)
  );

  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = b[i % 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren = 1'b0;
    wen = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ret_req = 1'b0; idle();
    ra = '0; wa = '0; di = '0;
    mcsrd = 2'b01; mcswr = 2'b10; adme = 3'b100;
    #1;
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid1 got %b exp 0", rvalid1); end
    checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL reset_rvalid2 got %b exp 0", rvalid2); end
    checks++; if (dout1 !== '0) begin errors++; $display("FAIL reset_dout1 got lo64 %h exp 0", dout1[63:0]); end
    checks++; if (dout2 !== '0) begin errors++; $display("FAIL reset_dout2 got lo64 %h exp 0", dout2[63:0]); end
    checks++; if (ret_ack1 !== 1'b0) begin errors++; $display("FAIL reset_ret_ack got %b exp 0", ret_ack1); end
    checks++; if (acc_err1 !== 1'b0) begin errors++; $display("FAIL reset_acc_err got %b exp 0", acc_err1); end
    step(); step();
    rstn = 1'b1;
    step();
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_rdy1 got %b exp 1", rdy1); end
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_rdy2 got %b exp 1", rdy2); end
    $display("txn reset released");
  endtask

  task automatic test_write_read();
    wen = 1'b1; wa = 8'h10; di = ones;
    step();
    idle();
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b exp 0", rvalid1); end
    step();
    ren = 1'b1; ra = 8'h10;
    step();
    idle();
    checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL rd1_rvalid got %b exp 1", rvalid1); end
    checks++; if (dout1 !== ones) begin errors++; $display("FAIL rd1_dout got lo64 %h exp lo64 %h", dout1[63:0], ones[63:0]); end
    checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL rd2_early_rvalid got %b exp 0", rvalid2); end
    pad_bits = dut1.g_slice[4].u_slice.DOUT[255:2];
    checks++; if (pad_bits !== '0) begin errors++; $display("FAIL pad_bits got lo64 %h exp 0", pad_bits[63:0]); end
    step();
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL rd1_rvalid_drop got %b exp 0", rvalid1); end
    checks++; if (dout1 !== ones) begin errors++; $display("FAIL rd1_hold got lo64 %h exp lo64 %h", dout1[63:0], ones[63:0]); end
    checks++; if (rvalid2 !== 1'b1) begin errors++; $display("FAIL rd2_rvalid got %b exp 1", rvalid2); end
    checks++; if (dout2 !== ones) begin errors++; $display("FAIL rd2_dout got lo64 %h exp lo64 %h", dout2[63:0], ones[63:0]); end
    step();
    checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL rd2_rvalid_drop got %b exp 0", rvalid2); end
    $display("txn write 0x10 all-ones, read back");
  endtask

  task automatic test_collision();
    wen = 1'b1; wa = 8'h20; di = pat_a5;
    step();
    idle();
    step();
    ren = 1'b1; wen = 1'b1; ra = 8'h20; wa = 8'h20; di = pat_5a;
    step();
    wen = 1'b0; di = '0;
    checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL coll_rvalid1 got %b exp 1", rvalid1); end
    checks++; if (dout1 !== pat_5a) begin errors++; $display("FAIL coll_dout1 got lo64 %h exp lo64 %h", dout1[63:0], pat_5a[63:0]); end
    step();
    idle();
    checks++; if (dout1 !== pat_5a) begin errors++; $display("FAIL coll_reread1 got lo64 %h exp lo64 %h", dout1[63:0], pat_5a[63:0]); end
    checks++; if (dout2 !== pat_5a) begin errors++; $display("FAIL coll_dout2 got lo64 %h exp lo64 %h", dout2[63:0], pat_5a[63:0]); end
    step();
    checks++; if (dout2 !== pat_5a) begin errors++; $display("FAIL coll_reread2 got lo64 %h exp lo64 %h", dout2[63:0], pat_5a[63:0]); end
    $display("txn collision at 0x20");
  endtask

  task automatic test_read_then_write();
    ren = 1'b1; ra = 8'h20;
    step();
    ren = 1'b0; wen = 1'b1; wa = 8'h20; di = pat_3c;
    step();
    checks++; if (dout1 !== pat_5a) begin errors++; $display("FAIL rtw_old1 got lo64 %h exp lo64 %h", dout1[63:0], pat_5a[63:0]); end
    wen = 1'b0; ren = 1'b1; ra = 8'h20;
    step();
    idle();
    checks++; if (dout1 !== pat_3c) begin errors++; $display("FAIL wtr_new1 got lo64 %h exp lo64 %h", dout1[63:0], pat_3c[63:0]); end
    checks++; if (dout2 !== pat_5a) begin errors++; $display("FAIL rtw_old2 got lo64 %h exp lo64 %h", dout2[63:0], pat_5a[63:0]); end
    step();
    checks++; if (dout2 !== pat_3c) begin errors++; $display("FAIL wtr_new2 got lo64 %h exp lo64 %h", dout2[63:0], pat_3c[63:0]); end
    $display("txn read-then-write and write-then-read at 0x20");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      wen = 1'b1; wa = AW'(k); di = DW'(k);
      step();
    end
    idle();
    for (int e = 0; e < 6; e++) begin
      ren = (e < 4); ra = AW'(e);
      step();
      if (e < 4) begin
        exp_d = DW'(e);
        checks++; if (rvalid1 !== 1'b1 || dout1 !== exp_d) begin errors++; $display("FAIL b2b_lat1_%0d got v=%b d=%0h exp v=1 d=%0h", e, rvalid1, dout1[15:0], exp_d[15:0]); end
      end else begin
        checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL b2b_lat1_%0d_end got v=%b exp 0", e, rvalid1); end
      end
      if (e >= 1 && e <= 4) begin
        exp_d = DW'(e - 1);
        checks++; if (rvalid2 !== 1'b1 || dout2 !== exp_d) begin errors++; $display("FAIL b2b_lat2_%0d got v=%b d=%0h exp v=1 d=%0h", e, rvalid2, dout2[15:0], exp_d[15:0]); end
      end else begin
        checks++; if (rvalid2 !== 1'b0) begin errors++; $display("FAIL b2b_lat2_%0d_edge got v=%b exp 0", e, rvalid2); end
      end
    end
    idle();
    $display("txn back-to-back reads of 0..3");
  endtask

  task automatic test_retention();
    ren = 1'b1; ra = 8'h10; ret_req = 1'b1;
    step();
    idle();
    checks++; if (rvalid1 !== 1'b1 || dout1 !== ones) begin errors++; $display("FAIL ret_read1 got v=%b lo64 %h exp v=1 all-ones", rvalid1, dout1[63:0]); end
    checks++; if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin errors++; $display("FAIL drain_rdy got %b%b exp 00", rdy1, rdy2); end
    step();
    checks++; if (ret_ack1 !== 1'b0) begin errors++; $display("FAIL drain_wait1 got %b exp 0", ret_ack1); end
    checks++; if (rvalid2 !== 1'b1 || dout2 !== ones) begin errors++; $display("FAIL ret_read2 got v=%b lo64 %h exp v=1 all-ones", rvalid2, dout2[63:0]); end
    step();
    checks++; if (ret_ack1 !== 1'b1) begin errors++; $display("FAIL retn_ack1 got %b exp 1", ret_ack1); end
    checks++; if (ret_ack2 !== 1'b0) begin errors++; $display("FAIL drain_wait2 got %b exp 0", ret_ack2); end
    step();
    checks++; if (ret_ack2 !== 1'b1 || ret_ack1 !== 1'b1) begin errors++; $display("FAIL retn_ack_both got %b%b exp 11", ret_ack1, ret_ack2); end
    step();
    checks++; if (rdy1 !== 1'b0 || ret_ack1 !== 1'b1) begin errors++; $display("FAIL retn_hold got rdy=%b ack=%b exp rdy=0 ack=1", rdy1, ret_ack1); end
    ret_req = 1'b0;
    step();
    checks++; if (ret_ack1 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL wake0 got ack=%b rdy=%b exp 0 0", ret_ack1, rdy1); end
    // access attempt while waking must be dropped and flagged
    ren = 1'b1; ra = 8'h10; wen = 1'b1; wa = 8'h10; di = '0;
    step();
    idle();
    checks++; if (acc_err1 !== 1'b1 || acc_err2 !== 1'b1) begin errors++; $display("FAIL acc_err_pulse got %b%b exp 11", acc_err1, acc_err2); end
    checks++; if (rvalid1 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL wake1 got v=%b rdy=%b exp 0 0", rvalid1, rdy1); end
    step();
    checks++; if (acc_err1 !== 1'b0) begin errors++; $display("FAIL acc_err_one_cycle got %b exp 0", acc_err1); end
    checks++; if (rvalid2 !== 1'b0 || rdy2 !== 1'b0) begin errors++; $display("FAIL wake2 got v=%b rdy=%b exp 0 0", rvalid2, rdy2); end
    step();
    checks++; if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin errors++; $display("FAIL wake3 got %b%b exp 00", rdy1, rdy2); end
    step();
    checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin errors++; $display("FAIL wake_done got %b%b exp 11", rdy1, rdy2); end
    ren = 1'b1; ra = 8'h10;
    step();
    idle();
    checks++; if (dout1 !== ones) begin errors++; $display("FAIL ret_preserve1 got lo64 %h exp all-ones", dout1[63:0]); end
    step();
    checks++; if (dout2 !== ones) begin errors++; $display("FAIL ret_preserve2 got lo64 %h exp all-ones", dout2[63:0]); end
    $display("txn retention entry/exit with gated access");
  endtask

  task automatic test_reset_midstream();
    for (int e = 0; e < 3; e++) begin
      ren = 1'b1; ra = AW'(e);
      step();
    end
    exp_d = DW'(1);
    checks++; if (rvalid2 !== 1'b1 || dout2 !== exp_d) begin errors++; $display("FAIL stream_pre got v=%b d=%0h exp v=1 d=1", rvalid2, dout2[15:0]); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (rvalid2 !== 1'b0 || dout2 !== '0) begin errors++; $display("FAIL arst_lat2 got v=%b lo64 %h exp v=0 d=0", rvalid2, dout2[63:0]); end
    checks++; if (rvalid1 !== 1'b0 || dout1 !== '0) begin errors++; $display("FAIL arst_lat1 got v=%b lo64 %h exp v=0 d=0", rvalid1, dout1[63:0]); end
    idle();
    step();
    rstn = 1'b1;
    step();
    checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1 || rvalid2 !== 1'b0) begin errors++; $display("FAIL post_rst got rdy=%b%b v=%b exp 11 0", rdy1, rdy2, rvalid2); end
    ren = 1'b1; ra = 8'h20;
    step();
    idle();
    checks++; if (dout1 !== pat_3c) begin errors++; $display("FAIL post_rst_data1 got lo64 %h exp lo64 %h", dout1[63:0], pat_3c[63:0]); end
    step();
    checks++; if (dout2 !== pat_3c) begin errors++; $display("FAIL post_rst_data2 got lo64 %h exp lo64 %h", dout2[63:0], pat_3c[63:0]); end
    $display("txn async reset during read stream");
  endtask

  initial begin
    ones   = '1;
    pat_a5 = pat(8'hA5);
    pat_5a = pat(8'h5A);
    pat_3c = pat(8'h3C);
    test_reset();
    test_write_read();
    test_collision();
    test_read_then_write();
    test_back_to_back();
    test_retention();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_1r1w_bypass_wrapper.md
Name: mem_1r1w_bypass_wrapper

Overview:
- Parametrised 1R1W SRAM wrapper for any DATA_WIDTH and DEPTH.
- Tiles one fixed-width two-port macro slice across the data word.
- Adds what flat width-split wrappers lack: a selectable read pipeline with RVALID, same-cycle write-to-read bypass, and a retention entry/exit handshake with drain and wake timing.
- Sits between datapath and macros, replacing per-size hand-written wrappers.

Parameters:
DATA_WIDTH, 1026, logical data word width
DEPTH, 256, number of words; AW = $clog2(DEPTH)
SLICE_WIDTH, 256, data width of one macro slice
RD_LAT, 1, read latency in cycles, legal values 1 or 2 (2 adds an output register)
WAKE_CYCLES, 4, cycles from retention release until RDY returns, >=1

Ports:
CK  in  1  clock, all state on rising edge
RSTN  in  1  asynchronous active-low reset
REN  in  1  read enable
WEN  in  1  write enable
RA  in  AW  read address
WA  in  AW  write address
DI  in  DATA_WIDTH  write data
DOUT  out  DATA_WIDTH  read data, valid when RVALID=1
RVALID  out  1  read data valid
RDY  out  1  accesses accepted this cycle
RET_REQ  in  1  level request for retention
RET_ACK  out  1  macros are in retention
ACC_ERR  out  1  one-cycle pulse when REN or WEN is asserted while RDY=0
MCSRD  in  2  margin control, passed to every slice
MCSWR  in  2  margin control, passed to every slice
ADME  in  3  margin control, passed to every slice

Behaviour:
- Slicing:
  - NUM_SLICES = ceil(DATA_WIDTH/SLICE_WIDTH).
  - Padded word = {zeros, DI}, width NUM_SLICES*SLICE_WIDTH.
  - Slice i receives padded[i*SLICE_WIDTH +: SLICE_WIDTH].
  - DOUT is the low DATA_WIDTH bits of the concatenated slice outputs; pad bits are never visible.
- Macro slice model: synchronous read; data appears the cycle after a REN edge.
- Access gating:
  - Slice REN = REN & RDY; slice WEN = WEN & RDY.
  - Gated-off accesses are dropped and ACC_ERR pulses in the following cycle.
- Read timing:
  - Read accepted at edge t gives RVALID=1 with DOUT for cycle t+RD_LAT.
  - Back-to-back reads give back-to-back RVALID.
  - RVALID=0 leaves DOUT holding its last value.
- Same-cycle collision (REN & WEN & RA==WA, both accepted):
  - Write commits.
  - Returned read data is DI from that cycle (new data), delivered with normal latency.
  - DI is captured into a bypass register and a bypass flag is pipelined alongside the read.
- Write at t followed by read of the same address at t+1 returns the new data from the macro; no bypass is used.
- Read issued at t is unaffected by a write to the same address at t+1, even when RD_LAT=2.
- Out-of-range addresses (>= DEPTH when DEPTH is not a power of 2): access is dropped and ACC_ERR pulses.
- Retention FSM states: RUN, DRAIN, RETN, WAKE.
  - RUN: RDY=1. RET_REQ=1 goes to DRAIN; the request is sampled at the edge, so accesses presented in that same cycle are still accepted.
  - DRAIN: RDY=0. Wait until no read is in flight (in-flight counter 0..2 equals 0), then go to RETN.
  - RETN: slice RET=1, RET_ACK=1. RET_REQ=0 goes to WAKE.
  - WAKE: RET=0, RDY=0. Down-counter loaded with WAKE_CYCLES; go to RUN when it reaches 0.
  - RET_REQ dropping during DRAIN still completes DRAIN→RETN→WAKE; there is no abort path.
- Reset (asynchronous, any time):
  - FSM=RUN.
  - RVALID=0, DOUT=0, RET_ACK=0, ACC_ERR=0, RDY=1 after reset release.
  - In-flight reads and the bypass pipeline are discarded.
  - Slice RET=0; memory contents are not cleared.

Decomposition:
- Package mem_wrap_pkg holds:
  - ret_state_e enum (RUN/DRAIN/RETN/WAKE);
  - function num_slices(dw, sw);
  - localparam pad width;
  - a RD_LAT legality check (elaboration $error if not 1 or 2).
- Sub-module mem_1r1w_slice: one SLICE_WIDTH x DEPTH two-port macro wrapper with CK/REN/WEN/RA/WA/DI/DOUT/RET/margin pins, instantiated NUM_SLICES times by a generate loop.
- Top level owns padding, gating, bypass, read pipeline and FSM.

Test Plan:
1. Default params (5 slices, 254 pad bits): write WA=0x10 DI=all-ones, then read RA=0x10 two cycles later → RVALID at t+1, DOUT all-ones (1026 bits), slice 4 upper 254 bits read 0.
2. Same-cycle collision: addr 0x20 holds 0xA5-pattern; REN=WEN=1, RA=WA=0x20, DI=0x5A-pattern → returned DOUT=0x5A-pattern. Re-read one cycle later → 0x5A-pattern.
3. RD_LAT=2, 4 consecutive reads of 0..3 holding 0,1,2,3 → RVALID high for 4 consecutive cycles starting at t+2, DOUT=0,1,2,3 in order.
4. Retention: read at t, RET_REQ=1 at t → DRAIN, then RETN after RVALID, RET_ACK=1. Drop RET_REQ → RDY returns after exactly 4 cycles; data at 0x10 is preserved.
5. REN=1 while RDY=0 (DRAIN or WAKE) → ACC_ERR pulses one cycle, no RVALID, memory unchanged.
6. RSTN low during RD_LAT=2 read stream → RVALID=0 and DOUT=0 immediately. After release RDY=1 and previously written data reads back intact.
